systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Drives the input side of the N x N systolic array: captures matrices A and B on a start request, builds the diagonally skewed row/column streams, and shifts them into the array one step per cycle while asserting the array's process enable.
- Signals completion once the last product has reached PE[N-1][N-1] and its output register.
- Sits between the host/load logic and the array. Its outputs connect port-for-port to the array's process-enable, row and column inputs.

Parameters:
- N, 4, array dimension; matrices are N x N of 8-bit unsigned elements.
- RUN_CYCLES, 3*N-1, number of cycles the process enable is held high. This is 3N-2 compute steps plus 1 for the PE output register. Localparam, not overridable.

Ports:
- i_clk  in  1  clock, rising edge.
- i_arst_n  in  1  asynchronous reset, active-low.
- i_start  in  1  single-cycle request to multiply; sampled only in IDLE.
- i_a  in  N*N*8  matrix A, [N-1:0][N-1:0][7:0], indexed [row][col].
- i_b  in  N*N*8  matrix B, [N-1:0][N-1:0][7:0], indexed [row][col].
- o_doProcess  out  1  process enable to the array.
- o_row  out  N*(2N-1)*8  skewed row streams, [N-1:0][(2*N)-2:0][7:0]. Element [i][0] is the current value for array row i.
- o_col  out  N*(2N-1)*8  skewed column streams, same shape. Element [j][0] is the current value for array column j.
- o_busy  out  1  high from LOAD through DONE inclusive.
- o_done  out  1  one-cycle pulse when the result matrix is valid at the array output.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, counter=0; o_row, o_col all zero; o_doProcess=0, o_busy=0, o_done=0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - i_start=1 -> LOAD next cycle.
  - i_start=0 -> stay; outputs hold zeros.
- LOAD (1 cycle): at the exiting edge, capture the skew images and go to RUN.
  - Row skew: o_row[i][k] = i_a[i][k-i] for i <= k < i+N, else 0.
  - Column skew: o_col[j][k] = i_b[k-j][j] for j <= k < j+N, else 0.
  - o_busy=1 during LOAD; o_doProcess=0.
- RUN:
  - o_doProcess=1 (registered, high for exactly RUN_CYCLES consecutive cycles).
  - On every RUN edge, each row/column vector shifts one place toward index 0: element [k] <= [k+1], top element [2N-2] <= 0.
  - Counter increments from 0. When counter == RUN_CYCLES-1, go to DONE and clear the counter.
- DONE (1 cycle): o_done=1, o_doProcess=0, o_busy=1; then IDLE.
- Skew vectors: after 2N-1 shifts all elements are zero and stay zero until the next LOAD.
- i_start while busy: ignored, not queued.
- i_start in the same cycle DONE is asserted: ignored. Starts are accepted from IDLE only.
- i_a/i_b are only sampled in LOAD; changes at any other time have no effect.
- Reset mid-RUN: everything immediately zero, o_doProcess drops asynchronously, no o_done pulse.
- The array accumulates across runs. The feeder does not clear PE accumulators; clearing is by reset only (host responsibility).
- Arithmetic: counter width $clog2(RUN_CYCLES+1). No wrap is reachable.
- Latency: i_start accepted at cycle t -> o_doProcess high over t+2 .. t+1+RUN_CYCLES -> o_done at t+2+RUN_CYCLES.

Decomposition:
- Shared package systolic_pkg holds:
  - localparam ELEM_W=8 and ACC_W=32;
  - typedef enum feeder_state_t {IDLE, LOAD, RUN, DONE};
  - function run_cycles(N) returning 3*N-1.
- One natural sub-module: skew_shift_reg. It is one lane: loads a 2N-1 element image, shifts toward index 0 with zero fill. It is instantiated N times for rows and N times for columns.
- The FSM and counter stay in systolic_feeder.

Test Plan:
- Reset: hold i_arst_n=0 with i_start=1 -> all outputs 0. Release -> still IDLE, o_busy=0.
- N=4, A=identity, B[r][c]=4r+c+1, pulse i_start:
  - first RUN cycle: o_row[0][0]=1, o_row[1][0]=0, o_col[3][0]=0;
  - o_doProcess high exactly 11 cycles; o_done pulse 1 cycle later;
  - array o_c equals B.
- N=4, A all 255, B all 255 -> array o_c every entry 260100 (4*255*255). Check o_col[j][k] skew: o_col[2][2..5]=255, others 0.
- Pulse i_start during RUN and again in the DONE cycle -> no second run, o_busy drops after a single o_done, total o_doProcess cycles = 11.
- Assert i_arst_n=0 mid-RUN at counter 5 -> o_doProcess=0 and o_row/o_col zero immediately, no o_done. A new i_start after release runs a full 11-cycle sequence.
- Change i_a during RUN -> skew outputs follow the values captured in LOAD only; result unchanged.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array front end.
package systolic_pkg;

    localparam int ELEM_W = 8;
    localparam int ACC_W  = 32;

    // Feeder control states: wait for a request, capture operands,
    // stream them into the array, flag the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } feeder_state_t;

    // Cycles the array must be enabled: 3N-2 compute steps for the last
    // operand pair to reach PE[N-1][N-1], plus one for its output register.
    function automatic int run_cycles(input int n);
        return 3 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_feeder_skew_shift_reg.sv
// One skewed operand lane: loads a full image, then shifts toward
// element 0 one place per step, filling the top with zero.
module skew_shift_reg
    import systolic_pkg::*;
#(
    parameter int LEN = 7
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         load,
    input  logic                         shift,
    input  logic [LEN-1:0][ELEM_W-1:0]   image,
    output logic [LEN-1:0][ELEM_W-1:0]   lane
);

    // Lane register: load has priority over shift; element 0 is what the
    // array sees this cycle.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            lane <= '0;
        end else if (load) begin
            lane <= image;
        end else if (shift) begin
            lane <= {{ELEM_W{1'b0}}, lane[LEN-1:1]};
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Input-side driver for an N x N systolic array: captures A and B on a
// start request, presents them as diagonally skewed row/column streams and
// holds the array's process enable for the full compute window.
//
// Handshake: i_start is a single-cycle request honoured only in IDLE;
// anything else is dropped, never queued. o_busy covers LOAD..DONE and
// o_done pulses for one cycle once the result is at the array output.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                                 i_clk,
    input  logic                                 i_arst_n,
    input  logic                                 i_start,
    input  logic [N-1:0][N-1:0][ELEM_W-1:0]      i_a,
    input  logic [N-1:0][N-1:0][ELEM_W-1:0]      i_b,
    output logic                                 o_doProcess,
    output logic [N-1:0][(2*N)-2:0][ELEM_W-1:0]  o_row,
    output logic [N-1:0][(2*N)-2:0][ELEM_W-1:0]  o_col,
    output logic                                 o_busy,
    output logic                                 o_done,
    output feeder_state_t                        o_state
);

    localparam int RUN_CYCLES = run_cycles(N);
    localparam int LEN        = 2 * N - 1;
    localparam int CNT_W      = $clog2(RUN_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(RUN_CYCLES - 1);

    feeder_state_t          state;
    feeder_state_t          next_state;
    logic [CNT_W-1:0]       counter;
    logic                   load;
    logic                   shift;
    logic                   do_process;
    logic                   busy;
    logic                   done;

    logic [N-1:0][LEN-1:0][ELEM_W-1:0] row_image;
    logic [N-1:0][LEN-1:0][ELEM_W-1:0] col_image;

    // State register; reset returns to IDLE immediately.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Run-length counter: counts RUN cycles and clears on the final one so
    // it is zero again whenever the FSM leaves RUN.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            counter <= '0;
        end else if (state == RUN) begin
            if (counter == LAST_COUNT) begin
                counter <= '0;
            end else begin
                counter <= counter + 1'b1;
            end
        end else begin
            counter <= '0;
        end
    end

    // Next-state and control decode; all outputs are pure functions of the
    // state register so they switch cleanly on the clock edge.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift      = 1'b0;
        do_process = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                busy       = 1'b1;
                load       = 1'b1;
                next_state = RUN;
            end
            RUN: begin
                busy       = 1'b1;
                shift      = 1'b1;
                do_process = 1'b1;
                if (counter == LAST_COUNT) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign o_doProcess = do_process;
    assign o_busy      = busy;
    assign o_done      = done;
    assign o_state     = state;

    // Skew images: row i is delayed by i slots, column j by j slots, so
    // matching operands meet in PE[i][j] on the same step.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        for (genvar gk = 0; gk < LEN; gk++) begin : g_slot
            if ((gk >= gi) && (gk < gi + N)) begin : g_live
                assign row_image[gi][gk] = i_a[gi][gk-gi];
                assign col_image[gi][gk] = i_b[gk-gi][gi];
            end else begin : g_pad
                assign row_image[gi][gk] = '0;
                assign col_image[gi][gk] = '0;
            end
        end

        skew_shift_reg #(
            .LEN (LEN)
        ) u_row (
            .clk    (i_clk),
            .arst_n (i_arst_n),
            .load   (load),
            .shift  (shift),
            .image  (row_image[gi]),
            .lane   (o_row[gi])
        );

        skew_shift_reg #(
            .LEN (LEN)
        ) u_col (
            .clk    (i_clk),
            .arst_n (i_arst_n),
            .load   (load),
            .shift  (shift),
            .image  (col_image[gi]),
            .lane   (o_col[gi])
        );
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: drives operand sets, models the
// array it feeds and checks control timing, skew images and products.
module tb_systolic_feeder;
    import systolic_pkg::*;

    localparam int N   = 4;
    localparam int LEN = 2 * N - 1;

    logic                             i_clk;
    logic                             i_arst_n;
    logic                             i_start;
    logic [N-1:0][N-1:0][7:0]         i_a;
    logic [N-1:0][N-1:0][7:0]         i_b;
    logic                             o_doProcess;
    logic [N-1:0][LEN-1:0][7:0]       o_row;
    logic [N-1:0][LEN-1:0][7:0]       o_col;
    logic                             o_busy;
    logic                             o_done;
    feeder_state_t                    o_state;

    // operand copies the expectations are computed from
    logic [7:0]  a_m [N][N];
    logic [7:0]  b_m [N][N];

    // array model
    logic [31:0] acc   [N][N];
    logic [7:0]  a_reg [N][N];
    logic [7:0]  b_reg [N][N];
    int          dp_count;
    int          done_count;
    logic        model_clear;

    logic [31:0] exp_q [$];
    int          num_checks;
    int          num_errors;

    systolic_feeder #(.N(N)) dut (
        .i_clk       (i_clk),
        .i_arst_n    (i_arst_n),
        .i_start     (i_start),
        .i_a         (i_a),
        .i_b         (i_b),
        .o_doProcess (o_doProcess),
        .o_row       (o_row),
        .o_col       (o_col),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_state     (o_state)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural N x N output-stationary array fed from element 0 of each
    // stream; also counts enable cycles and done pulses.
    always @(posedge i_clk) begin
        logic [7:0] a_in;
        logic [7:0] b_in;
        if (model_clear) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc[i][j]   = '0;
                    a_reg[i][j] = '0;
                    b_reg[i][j] = '0;
                end
            end
            dp_count   = 0;
            done_count = 0;
        end else begin
            if (o_doProcess) begin
                dp_count++;
                for (int i = N - 1; i >= 0; i--) begin
                    for (int j = N - 1; j >= 0; j--) begin
                        if (j == 0) a_in = o_row[i][0];
                        else        a_in = a_reg[i][j-1];
                        if (i == 0) b_in = o_col[j][0];
                        else        b_in = b_reg[i-1][j];
                        acc[i][j]   = acc[i][j] + 32'(a_in) * 32'(b_in);
                        a_reg[i][j] = a_in;
                        b_reg[i][j] = b_in;
                    end
                end
            end
            if (o_done) done_count++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic apply_operands();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                i_a[r][c] = a_m[r][c];
                i_b[r][c] = b_m[r][c];
            end
        end
    endtask

    task automatic clear_model();
        @(negedge i_clk);
        model_clear = 1'b1;
        @(negedge i_clk);
        model_clear = 1'b0;
    endtask

    // returns at the negedge inside the LOAD cycle
    task automatic start_run();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int c = 0; c < 40; c++) begin
            if (o_done) begin
                cycles = c;
                return;
            end
            @(negedge i_clk);
        end
    endtask

    task automatic push_product();
        logic [31:0] s;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < N; k++) s = s + 32'(a_m[i][k]) * 32'(b_m[k][j]);
                exp_q.push_back(s);
            end
        end
    endtask

    task automatic check_products(input string tag);
        logic [31:0] e;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_queue_empty"}, 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("%s_c%0d%0d", tag, i, j), 64'(acc[i][j]), 64'(e));
                end
            end
        end
    endtask

    // full run from start to done with timing checks
    task automatic full_run(input string tag);
        int cyc;
        clear_model();
        start_run();
        check({tag, "_load_busy"}, 64'(o_busy), 64'd1);
        check({tag, "_load_dp"}, 64'(o_doProcess), 64'd0);
        @(negedge i_clk);
        check({tag, "_run_dp"}, 64'(o_doProcess), 64'd1);
        wait_done(cyc);
        check({tag, "_latency"}, 64'(cyc), 64'd11);
        check({tag, "_dp_cycles"}, 64'(dp_count), 64'd11);
        check({tag, "_dp_low_at_done"}, 64'(o_doProcess), 64'd0);
        check_products(tag);
        @(negedge i_clk);
        check({tag, "_done_pulse"}, 64'(o_done), 64'd0);
        check({tag, "_idle_busy"}, 64'(o_busy), 64'd0);
        check({tag, "_done_count"}, 64'(done_count), 64'd1);
    endtask

    initial begin
        int cyc;
        num_checks  = 0;
        num_errors  = 0;
        model_clear = 1'b1;
        i_arst_n    = 1'b0;
        i_start     = 1'b1;
        i_a         = '0;
        i_b         = '0;

        // reset held with start asserted
        repeat (3) @(negedge i_clk);
        check("rst_dp", 64'(o_doProcess), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_row_zero", 64'(|o_row), 64'd0);
        check("rst_col_zero", 64'(|o_col), 64'd0);
        check("rst_state", 64'(o_state), 64'(IDLE));
        i_start  = 1'b0;
        i_arst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        check("post_rst_state", 64'(o_state), 64'(IDLE));
        check("post_rst_busy", 64'(o_busy), 64'd0);

        // identity A, B[r][c] = 4r+c+1: product equals B
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                a_m[r][c] = (r == c) ? 8'd1 : 8'd0;
                b_m[r][c] = 8'(4 * r + c + 1);
                exp_q.push_back(32'(4 * r + c + 1));
            end
        end
        apply_operands();
        clear_model();
        start_run();
        @(negedge i_clk);
        check("id_row00", 64'(o_row[0][0]), 64'd1);
        check("id_row10", 64'(o_row[1][0]), 64'd0);
        check("id_col30", 64'(o_col[3][0]), 64'd0);
        check("id_col00", 64'(o_col[0][0]), 64'd1);
        check("id_row11", 64'(o_row[1][1]), 64'd0);
        check("id_row12", 64'(o_row[1][2]), 64'd1);
        wait_done(cyc);
        check("id_latency", 64'(cyc), 64'd11);
        check("id_dp_cycles", 64'(dp_count), 64'd11);
        check_products("id");
        @(negedge i_clk);
        check("id_done_pulse", 64'(o_done), 64'd0);
        check("id_idle_busy", 64'(o_busy), 64'd0);

        // all 255: every product is 4*255*255 = 260100
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                a_m[r][c] = 8'd255;
                b_m[r][c] = 8'd255;
                exp_q.push_back(32'd260100);
            end
        end
        apply_operands();
        clear_model();
        start_run();
        @(negedge i_clk);
        for (int k = 0; k < LEN; k++) begin
            check($sformatf("max_col2_%0d", k), 64'(o_col[2][k]),
                  (k >= 2 && k <= 5) ? 64'd255 : 64'd0);
        end
        wait_done(cyc);
        check("max_latency", 64'(cyc), 64'd11);
        check_products("max");

        // start requests during RUN and in the DONE cycle are dropped
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                a_m[r][c] = 8'(r + 2 * c + 1);
                b_m[r][c] = 8'(3 * r + c + 2);
            end
        end
        apply_operands();
        push_product();
        clear_model();
        start_run();
        repeat (3) @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done(cyc);
        check("ign_done_seen", 64'(cyc >= 0), 64'd1);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("ign_state_idle", 64'(o_state), 64'(IDLE));
        check("ign_busy_drop", 64'(o_busy), 64'd0);
        repeat (15) @(negedge i_clk);
        check("ign_done_count", 64'(done_count), 64'd1);
        check("ign_dp_cycles", 64'(dp_count), 64'd11);
        check("ign_still_idle", 64'(o_busy), 64'd0);
        check_products("ign");

        // reset in the RUN cycle where the counter is 5
        clear_model();
        start_run();
        repeat (6) @(negedge i_clk);
        check("mid_rst_pre_state", 64'(o_state), 64'(RUN));
        #2 i_arst_n = 1'b0;
        #1;
        check("mid_rst_dp", 64'(o_doProcess), 64'd0);
        check("mid_rst_row", 64'(|o_row), 64'd0);
        check("mid_rst_col", 64'(|o_col), 64'd0);
        check("mid_rst_busy", 64'(o_busy), 64'd0);
        @(negedge i_clk);
        i_arst_n = 1'b1;
        repeat (15) @(negedge i_clk);
        check("mid_rst_no_done", 64'(done_count), 64'd0);
        push_product();
        full_run("after_rst");

        // A changes after capture: streams and products use the LOAD values
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                a_m[r][c] = 8'(7 * r + c + 10);
                b_m[r][c] = 8'(r * c + 1);
            end
        end
        apply_operands();
        push_product();
        clear_model();
        start_run();
        @(negedge i_clk);
        i_a = {N*N{8'hAA}};
        @(negedge i_clk);
        check("chg_row00", 64'(o_row[0][0]), 64'(a_m[0][1]));
        check("chg_row10", 64'(o_row[1][0]), 64'(a_m[1][0]));
        wait_done(cyc);
        check("chg_latency", 64'(cyc), 64'd10);
        check_products("chg");

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
